// File: rtl/main_div_pkg.sv
// Shared types, constants and sign helpers for the iterative signed divider.
package main_div_pkg;

    localparam int DIV_W = 31;
    localparam int CNT_W = $clog2(DIV_W);

    // Quotient reported on division by zero: all ones, i.e. -1.
    localparam logic [DIV_W-1:0] DBZ_QUOT = {DIV_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Two's-complement negate when neg is set, pass through otherwise.
    function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic neg);
        if (neg) begin
            return (~v) + DIV_W'(1);
        end else begin
            return v;
        end
    endfunction

    // Magnitude of a signed value as unsigned; the most negative value maps onto 2^(W-1).
    function automatic logic [DIV_W-1:0] abs_mag(input logic [DIV_W-1:0] v);
        return cond_neg(v, v[DIV_W-1]);
    endfunction

endpackage

// File: rtl/main_sdiv_31s_31s_31_seq_if.sv
// Start/done handshake and data bus of the signed divider.
interface main_sdiv_31s_31s_31_seq_if;
    import main_div_pkg::*;

    logic             ce;
    logic             start;
    logic             ready;
    logic [DIV_W-1:0] din0;
    logic [DIV_W-1:0] din1;
    logic             done;
    logic [DIV_W-1:0] quot;
    logic [DIV_W-1:0] remd;
    logic             div_by_zero;

    modport master (
        output ce, start, din0, din1,
        input  ready, done, quot, remd, div_by_zero
    );

    modport slave (
        input  ce, start, din0, din1,
        output ready, done, quot, remd, div_by_zero
    );
endinterface

// File: rtl/main_sdiv_restoring_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract, keep or restore.
module main_sdiv_restoring_step
    import main_div_pkg::*;
(
    input  logic [DIV_W:0]   rem_i,
    input  logic             bit_i,
    input  logic [DIV_W-1:0] dvsr_i,
    output logic [DIV_W:0]   rem_o,
    output logic             q_o
);

    logic [DIV_W+1:0] shifted_s;
    logic [DIV_W:0]   diff_s;
    logic             borrow_s;

    // Trial subtraction of the divisor magnitude from the shifted remainder.
    always_comb begin
        shifted_s = {rem_i, bit_i};
        borrow_s  = (shifted_s < {2'b00, dvsr_i});
        diff_s    = shifted_s[DIV_W:0] - {1'b0, dvsr_i};
        if (borrow_s) begin
            rem_o = shifted_s[DIV_W:0];
        end else begin
            rem_o = diff_s;
        end
        q_o = ~borrow_s;
    end

endmodule

// File: rtl/main_sdiv_31s_31s_31_seq.sv
// Iterative signed divider (truncating toward zero) with a start/done handshake.
module main_sdiv_31s_31s_31_seq
    import main_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 33,
    parameter int din0_WIDTH = 31,
    parameter int din1_WIDTH = 31,
    parameter int dout_WIDTH = 31
) (
    input  logic                         clk,
    input  logic                         reset,
    main_sdiv_31s_31s_31_seq_if.slave    bus
);

    localparam int W = DIV_W;

    localparam bit PARAMS_OK = (din0_WIDTH == W) && (din1_WIDTH == din0_WIDTH) &&
                               (dout_WIDTH == din0_WIDTH) && (NUM_STAGE == din0_WIDTH + 2) &&
                               (ID >= 0);
    if (!PARAMS_OK) begin : g_bad_params
        $error("main_sdiv_31s_31s_31_seq: inconsistent width/stage parameters");
    end

    div_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           sign_q_q, sign_q_d;
    logic           sign_r_q, sign_r_d;
    logic           dbz_q, dbz_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   quot_q, quot_d;
    logic [W-1:0]   remd_q, remd_d;
    logic           dbzo_q, dbzo_d;
    logic           done_q, done_d;
    logic           ready_q, ready_d;

    logic [W:0]     step_rem_s;
    logic           step_q_s;

    // Dividend magnitude is kept intact and walked MSB first by the counter.
    main_sdiv_restoring_step u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[cnt_q]),
        .dvsr_i (dvs_q),
        .rem_o  (step_rem_s),
        .q_o    (step_q_s)
    );

    // Next-state and output-register logic of the divide sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        dbz_d    = dbz_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        quot_d   = quot_q;
        remd_d   = remd_q;
        dbzo_d   = dbzo_q;
        done_d   = done_q;
        ready_d  = ready_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    sign_q_d = bus.din0[W-1] ^ bus.din1[W-1];
                    sign_r_d = bus.din0[W-1];
                    dvd_d    = abs_mag(bus.din0);
                    dvs_d    = abs_mag(bus.din1);
                    dbz_d    = (bus.din1 == {W{1'b0}});
                    rem_d    = {(W+1){1'b0}};
                    quo_d    = {W{1'b0}};
                    cnt_d    = CNT_W'(W - 1);
                    state_d  = ITER;
                    done_d   = 1'b0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = IDLE;
                    done_d   = 1'b0;
                    ready_d  = 1'b1;
                end
            end
            ITER: begin
                rem_d = step_rem_s;
                quo_d = {quo_q[W-2:0], step_q_s};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                if (dbz_q) begin
                    // Rebuild the original dividend from its magnitude and sign.
                    quot_d = DBZ_QUOT;
                    remd_d = cond_neg(dvd_q, sign_r_q);
                    dbzo_d = 1'b1;
                end else begin
                    quot_d = cond_neg(quo_q, sign_q_q);
                    remd_d = cond_neg(rem_q[W-1:0], sign_r_q);
                    dbzo_d = 1'b0;
                end
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and result registers: synchronous reset wins, otherwise advance only on ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            dbz_q    <= 1'b0;
            dvd_q    <= {W{1'b0}};
            dvs_q    <= {W{1'b0}};
            rem_q    <= {(W+1){1'b0}};
            quo_q    <= {W{1'b0}};
            quot_q   <= {W{1'b0}};
            remd_q   <= {W{1'b0}};
            dbzo_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else if (bus.ce) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            dbz_q    <= dbz_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            quot_q   <= quot_d;
            remd_q   <= remd_d;
            dbzo_q   <= dbzo_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quot        = quot_q;
    assign bus.remd        = remd_q;
    assign bus.div_by_zero = dbzo_q;

endmodule

// File: doc/main_sdiv_31s_31s_31_seq.md
Name: main_sdiv_31s_31s_31_seq

Overview:
- Iterative signed divider; the inverse of the 31-bit signed pipelined multiplier used by the mloc datapath.
- Computes quotient and remainder with truncation toward zero, C semantics.
- Uses a start/done handshake so the HLS scheduler can hand off a divide and poll for completion.
- Radix-2 restoring algorithm: one quotient bit per enabled cycle, no DSP use.

Parameters:
- ID, 1, instance tag; informational only.
- NUM_STAGE, 33, informational; equals the start-to-done latency in enabled cycles, din0_WIDTH+2.
- din0_WIDTH, 31, dividend width, signed.
- din1_WIDTH, 31, divisor width, signed; must equal din0_WIDTH.
- dout_WIDTH, 31, quotient and remainder width; must equal din0_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state holds.
- start  in  1  request; accepted only when ce=1 and ready=1.
- ready  out  1  high in IDLE and DONE; a new start is accepted.
- din0  in  din0_WIDTH  dividend, sampled on the accepting edge.
- din1  in  din1_WIDTH  divisor, sampled on the accepting edge.
- done  out  1  one-enabled-cycle pulse when results become valid.
- quot  out  dout_WIDTH  signed quotient; holds until the next accepted start completes.
- remd  out  dout_WIDTH  signed remainder; sign follows the dividend.
- div_by_zero  out  1  set with done when din1==0; holds with the results.

Behaviour:
- Reset, when reset=1 at a clock edge, regardless of ce:
  - state=IDLE, ready=1, done=0, quot=0, remd=0, div_by_zero=0.
  - Any in-flight operation is discarded and produces no done.
- ce=0: state, counters, internal registers and all outputs hold, including done. A done pulse is therefore stretched across stalled cycles.
- States: IDLE, ITER, FIX, DONE. All transitions require ce=1.
- IDLE/DONE with start=1 (accepting edge):
  - Capture sign_q = din0[msb]^din1[msb] and sign_r = din0[msb].
  - Capture |din0| and |din1| as unsigned W-bit values. |MIN| = 2^(W-1) fits unsigned.
  - Capture dbz = (din1==0). Clear the partial remainder; cnt=W-1; go to ITER.
  - done=0 and ready=0 from this edge.
- IDLE/DONE with start=0: DONE returns to IDLE; done=0; outputs hold.
- ITER: each edge does one restoring step on a (W+1)-bit partial remainder:
  - shift in the next dividend bit, MSB first;
  - trial subtract the divisor magnitude;
  - quotient bit = no-borrow; keep the difference if no borrow.
  - When cnt==0 go to FIX, otherwise decrement cnt. Exactly W ITER cycles.
- FIX (1 cycle):
  - quot = sign_q ? -q : q and remd = sign_r ? -r : r, both truncated to W bits.
  - If dbz: override quot = all ones (-1), remd = original din0, div_by_zero=1; otherwise div_by_zero=0.
  - done=1 and go to DONE.
- Latency: the accepting edge is cycle 0; done is high after edge W+1, i.e. NUM_STAGE=W+2 enabled cycles including the accepting edge.
- Back-to-back: start is accepted while in DONE, so throughput is one divide per W+2 enabled cycles.
- start while busy (ITER/FIX) is ignored; no queuing and no error flag.
- Overflow: MIN / -1 yields quot=MIN through natural wrap, remd=0, no flag.
- The inputs din0/din1 may change freely after acceptance.

Decomposition:
- Shared package main_div_pkg:
  - state enum {IDLE, ITER, FIX, DONE};
  - localparam CNT_W = $clog2(W);
  - the dbz quotient constant (all ones).
- One natural sub-module: main_sdiv_restoring_step. It is combinational: it takes the partial remainder, the next dividend bit and the divisor magnitude, and returns the new remainder and the quotient bit. It is instantiated once, in ITER.

Test Plan:
- 100 / 7, ce=1 -> after 33 cycles done=1 for one cycle; quot=14, remd=2, div_by_zero=0; ready low for cycles 1..32.
- Sign mix -> -100/7 gives quot=-14, remd=-2; 100/-7 gives -14, 2; -100/-7 gives 14, -2.
- Boundary -> MIN(0x40000000)/-1 gives quot=0x40000000, remd=0; MIN/1 gives MIN, 0; 5/0 gives quot=0x7FFFFFFF (all ones), remd=5, div_by_zero=1.
- ce stall:
  - 100/7 with ce toggled 1,0,1,0 for the whole run -> done only after 33 enabled cycles, results identical;
  - ce held low while done=1 -> done stays high, outputs hold.
- Busy and back-to-back:
  - start 40/3 pulsed again at cycle 10 with 9/2 -> second start ignored; quot=13, remd=1;
  - then start 9/2 in the done cycle -> quot=4, remd=1 exactly 33 cycles later.
- Reset mid-operation: assert reset at cycle 15 of 1000/10 -> next edge ready=1, done=0, quot=remd=0; no done appears afterwards; a subsequent 1000/10 gives 100, 0.
